uart_tx_arb: RTL and testbench

Packet-atomic round-robin arbiter that shares one UART transmitter between N_SRC byte sources.
- Each source is a show-ahead (first-word-fall-through) FIFO that tags the final byte of each packet.
- The block grants one source at a time and streams that source's packet bytes into a one-byte stage register, which feeds the transmitter's empty/ready handshake.
- Once the transmitter accepts a byte, the block holds that byte stable on uart_data for the whole serial frame.
- Sits between the PS/PL message FIFOs and the UART transmitter in the PL top level.

---
 rtl/uart_tx_arb_pkg.sv | 5 +
 rtl/uart_tx_arb_rr_pick.sv | 22 ++
 rtl/uart_tx_arb.sv | 114 +++++++++++
 tb/tb_uart_tx_arb.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: shared FSM encoding and default timeout for the UART source arbiter
package uart_tx_arb_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    localparam int TIMEOUT_CYC_DEF = 50000;
endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// rr_pick: combinational round-robin search starting at ptr and wrapping modulo N
module rr_pick #(
    parameter int N = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          hit
);
    logic [IW-1:0] cand;
    // scan farthest-first so the candidate nearest to ptr is the last one written
    always_comb begin
        idx = '0;
        cand = '0;
        hit = |req;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr) + k) % N);
            if (req[cand]) idx = cand;
        end
    end
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: packet-atomic round-robin arbiter feeding one UART transmitter from N_SRC FIFOs
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int N_SRC = 2,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    localparam int IDX_W = $clog2(N_SRC)
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [N_SRC-1:0]     src_empty,
    input  logic [8*N_SRC-1:0]   src_data,
    input  logic [N_SRC-1:0]     src_last,
    output logic [N_SRC-1:0]     src_rd,
    output logic                 uart_empty,
    input  logic                 uart_ready,
    output logic [7:0]           uart_data,
    output logic                 grant_vld,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 pkt_done,
    output logic                 timeout_err
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    state_t state, state_nx;
    logic [IDX_W-1:0] rr_ptr, win_idx, next_ptr;
    logic [CNT_W-1:0] tmo_cnt;
    logic [7:0] stage_byte, head_byte;
    logic win_hit, stage_valid, stage_last, head_empty, head_last;
    logic pop, fetch_wait, tmo, grant_start, release_grant, accept;

    rr_pick #(.N(N_SRC), .IW(IDX_W)) u_pick (
        .req (~src_empty),
        .ptr (rr_ptr),
        .idx (win_idx),
        .hit (win_hit)
    );

    assign head_empty    = src_empty[grant_idx];
    assign head_last     = src_last[grant_idx];
    assign head_byte     = src_data[{grant_idx, 3'b000} +: 8];
    assign accept        = uart_ready && stage_valid;
    assign pop           = state == FETCH && !stage_valid && !head_empty;
    assign fetch_wait    = state == FETCH && !stage_valid && head_empty;
    assign tmo           = fetch_wait && tmo_cnt == CNT_MAX;
    assign grant_start   = state == IDLE && !stage_valid && win_hit;
    assign release_grant = tmo || (state == DRAIN && !stage_valid);
    assign next_ptr      = grant_idx == IDX_W'(N_SRC - 1) ? '0 : grant_idx + 1'b1;

    // state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else state <= state_nx;
    end

    // next-state: grant on a hit, drain after the last byte, abandon on timeout
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = grant_start ? FETCH : IDLE;
            FETCH:   state_nx = pop && head_last ? DRAIN : tmo ? IDLE : FETCH;
            DRAIN:   state_nx = stage_valid ? DRAIN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // outputs: pop strobe for the granted source only, empty flag to the transmitter
    always_comb begin
        src_rd = '0;
        src_rd[grant_idx] = pop;
        uart_empty = ~stage_valid;
    end

    // stage register, transmit hold register, grant bookkeeping and timeout counter
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rr_ptr      <= '0;
            stage_valid <= 1'b0;
            stage_byte  <= '0;
            stage_last  <= 1'b0;
            uart_data   <= '0;
            grant_vld   <= 1'b0;
            grant_idx   <= '0;
            pkt_done    <= 1'b0;
            timeout_err <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            pkt_done    <= accept && stage_last;
            timeout_err <= tmo;
            if (accept) begin
                uart_data   <= stage_byte;
                stage_valid <= 1'b0;
            end
            if (pop) begin
                stage_byte  <= head_byte;
                stage_last  <= head_last;
                stage_valid <= 1'b1;
                tmo_cnt     <= '0;
            end else if (fetch_wait) begin
                tmo_cnt <= tmo ? '0 : tmo_cnt + 1'b1;
            end
            if (grant_start) begin
                grant_idx <= win_idx;
                grant_vld <= 1'b1;
                tmo_cnt   <= '0;
            end
            if (release_grant) begin
                grant_vld <= 1'b0;
                rr_ptr    <= next_ptr;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: scoreboard bench with FIFO source models and a transmitter model
module tb_uart_tx_arb;
    localparam int N = 2;
    localparam int TO = 16;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] src_empty = '1;
    logic [8*N-1:0] src_data = '0;
    logic [N-1:0] src_last = '0;
    logic [N-1:0] src_rd;
    logic uart_empty;
    logic uart_ready = 1'b0;
    logic [7:0] uart_data;
    logic grant_vld;
    logic [0:0] grant_idx;
    logic pkt_done, timeout_err;

    ent_t q0[$], q1[$], exp_q[$];
    int exp_src[$];
    ent_t mon_e;
    int passed = 0, total = 0;
    logic [N-1:0] rd_n = '0;
    logic tx_en = 1'b0, man_req = 1'b0, acc_prev = 1'b0;
    int tx_delay = 5, tx_cnt = 0, n;

    uart_tx_arb #(.N_SRC(N), .TIMEOUT_CYC(TO)) dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .src_empty   (src_empty),
        .src_data    (src_data),
        .src_last    (src_last),
        .src_rd      (src_rd),
        .uart_empty  (uart_empty),
        .uart_ready  (uart_ready),
        .uart_data   (uart_data),
        .grant_vld   (grant_vld),
        .grant_idx   (grant_idx),
        .pkt_done    (pkt_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    endtask

    task automatic fail(input string nm);
        total++;
        $display("FAIL %s", nm);
    endtask

    task automatic put(input int s, input logic [7:0] d, input logic l);
        ent_t e;
        e.d = d;
        e.l = l;
        if (s == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic exp_b(input int s, input logic [7:0] d, input logic l);
        ent_t e;
        e.d = d;
        e.l = l;
        exp_q.push_back(e);
        exp_src.push_back(s);
    endtask

    task automatic wait_empty(input logic v, input string nm);
        int k = 0;
        while (uart_empty !== v && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) fail(nm);
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (!(grant_vld == 1'b0 && uart_empty && q0.size() == 0 && q1.size() == 0 &&
                 exp_q.size() == 0) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) fail(nm);
    endtask

    // source FIFO model: apply pops granted at the previous edge, then present the heads
    always @(negedge clk) rd_n = src_rd;
    always @(posedge clk) begin
        #1;
        if (rd_n[0] && q0.size() > 0) q0.delete(0);
        if (rd_n[1] && q1.size() > 0) q1.delete(0);
        src_empty = {q1.size() == 0, q0.size() == 0};
        src_data  = {q1.size() > 0 ? q1[0].d : 8'h00, q0.size() > 0 ? q0[0].d : 8'h00};
        src_last  = {q1.size() > 0 ? q1[0].l : 1'b0, q0.size() > 0 ? q0[0].l : 1'b0};
    end

    // transmitter model: one-cycle ready pulse tx_delay cycles after a byte is staged
    always @(posedge clk) begin
        #1;
        if (uart_ready) begin
            uart_ready = 1'b0;
            tx_cnt = 0;
        end else if (man_req) begin
            uart_ready = 1'b1;
            man_req = 1'b0;
        end else if (tx_en && !uart_empty && rst_n) begin
            tx_cnt++;
            if (tx_cnt >= tx_delay) uart_ready = 1'b1;
        end else tx_cnt = 0;
    end

    // monitor: scoreboard check of every accepted byte and every source pop
    always @(negedge clk) begin
        if (!rst_n) acc_prev = 1'b0;
        else begin
            if (acc_prev) begin
                if (exp_q.size() == 0) fail("unexpected_accept");
                else begin
                    mon_e = exp_q.pop_front();
                    chk("uart_data", uart_data, mon_e.d);
                    chk("pkt_done", pkt_done, mon_e.l);
                end
            end else chk("no_stray_pkt_done", pkt_done, 0);
            if (src_rd != '0) begin
                chk("src_rd_onehot", $onehot(src_rd), 1);
                if (exp_src.size() == 0) fail("unexpected_src_rd");
                else chk("src_rd_source", src_rd, 32'(1) << exp_src.pop_front());
            end
            acc_prev = uart_ready && !uart_empty;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_uart_empty", uart_empty, 1);
        chk("rst_uart_data", uart_data, 0);
        chk("rst_grant_vld", grant_vld, 0);
        chk("rst_src_rd", src_rd, 0);
        chk("rst_pkt_done", pkt_done, 0);
        chk("rst_timeout_err", timeout_err, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tx_en = 1'b1;

        @(posedge clk);
        #2;
        put(0, 8'h41, 0); put(0, 8'h42, 0); put(0, 8'h43, 1);
        exp_b(0, 8'h41, 0); exp_b(0, 8'h42, 0); exp_b(0, 8'h43, 1);
        wait_idle("pkt_a_idle");
        chk("pkt_a_final_data", uart_data, 8'h43);
        chk("pkt_a_grant_fell", grant_vld, 0);

        @(posedge clk);
        #2 man_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("stray_uart_empty", uart_empty, 1);
        chk("stray_grant_vld", grant_vld, 0);
        chk("stray_uart_data", uart_data, 8'h43);

        tx_en = 1'b0;
        @(posedge clk);
        #2;
        put(0, 8'h55, 0); put(0, 8'hAA, 1);
        exp_b(0, 8'h55, 0); exp_b(0, 8'hAA, 1);
        wait_empty(1'b0, "hold_stage");
        @(posedge clk);
        #2 man_req = 1'b1;
        repeat (4) @(negedge clk);
        chk("hold_data_a", uart_data, 8'h55);
        chk("hold_aa_staged", uart_empty, 0);
        repeat (6) @(negedge clk);
        chk("hold_data_b", uart_data, 8'h55);
        tx_en = 1'b1;
        wait_idle("hold_idle");

        @(posedge clk);
        #2;
        put(0, 8'h01, 0);
        exp_b(0, 8'h01, 0);
        wait_empty(1'b0, "to_stage");
        @(posedge clk);
        #2;
        put(1, 8'h77, 1);
        exp_b(1, 8'h77, 1);
        wait_empty(1'b1, "to_accept");
        n = 0;
        while (!timeout_err && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_latency", n, TO);
        chk("timeout_grant_drop", grant_vld, 0);
        @(negedge clk);
        chk("timeout_pulse_width", timeout_err, 0);
        chk("timeout_regrant_vld", grant_vld, 1);
        chk("timeout_regrant_idx", grant_idx, 1);
        wait_idle("timeout_idle");

        @(posedge clk);
        #2;
        put(0, 8'h10, 0); put(0, 8'h11, 1);
        put(1, 8'h20, 0); put(1, 8'h21, 1);
        exp_b(0, 8'h10, 0); exp_b(0, 8'h11, 1);
        exp_b(1, 8'h20, 0); exp_b(1, 8'h21, 1);
        exp_b(0, 8'h30, 0); exp_b(0, 8'h31, 1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        put(0, 8'h30, 0); put(0, 8'h31, 1);
        wait_idle("rr_idle");
        chk("rr_final_data", uart_data, 8'h31);

        @(posedge clk);
        #2;
        put(1, 8'hE0, 0); put(1, 8'hE1, 0); put(1, 8'hE2, 1);
        exp_src.push_back(1);
        wait_empty(1'b0, "reset_stage");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_uart_empty", uart_empty, 1);
        chk("mid_rst_uart_data", uart_data, 0);
        chk("mid_rst_grant_vld", grant_vld, 0);
        chk("mid_rst_grant_idx", grant_idx, 0);
        chk("mid_rst_src_rd", src_rd, 0);
        q0.delete(); q1.delete(); exp_q.delete(); exp_src.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #2;
        put(1, 8'hD1, 1); put(0, 8'hC1, 1);
        exp_b(0, 8'hC1, 1); exp_b(1, 8'hD1, 1);
        wait_idle("post_rst_idle");
        chk("post_rst_final_data", uart_data, 8'hD1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
